// File: rtl/mem_access_unit.sv
// Sequenced big-endian load/store unit driving a DW-bit Avalon-style bus.
// Misaligned accesses are either split into two bus beats or faulted, depending on SPLIT_EN.
module mem_access_unit #(
  parameter int DW       = 32,
  parameter int AW       = 32,
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            req,
  input  logic            we,
  input  logic [1:0]      size,
  input  logic            sign,
  input  logic [AW-1:0]   addr,
  input  logic [DW-1:0]   wdata,
  output logic [DW-1:0]   rdata,
  output logic            ack,
  output logic            fault,
  output logic [1:0]      fault_cause,
  output logic            busy,
  output logic [AW-1:0]   address,
  output logic            read,
  output logic            write,
  input  logic            waitrequest,
  input  logic [DW-1:0]   readdata,
  output logic [DW-1:0]   writedata,
  output logic [DW/8-1:0] byteenable,
  input  logic            busfault
);
  localparam int NB = DW / 8;
  localparam int LB = $clog2(NB);
  localparam int IW = LB + 2;

  typedef enum logic [2:0] {S_IDLE, S_BEAT1, S_BEAT2, S_DONE, S_ERR} state_t;

  state_t          r_state;
  logic            r_we;
  logic            r_sign;
  logic            r_split;
  logic [1:0]      r_size;
  logic [LB-1:0]   r_off;
  logic [AW-1:0]   r_base;
  logic [DW-1:0]   r_wdata;
  logic [DW-1:0]   r_acc;
  logic [DW-1:0]   r_rdata;
  logic            r_ack;
  logic            r_fault;
  logic [1:0]      r_cause;
  logic            r_busy;
  logic [AW-1:0]   r_address;
  logic            r_read;
  logic            r_write;
  logic [DW-1:0]   r_writedata;
  logic [NB-1:0]   r_be;

  logic            w_idle;
  logic            w_src_we;
  logic [1:0]      w_src_size;
  logic [LB-1:0]   w_src_off;
  logic [DW-1:0]   w_src_wdata;
  logic [IW-1:0]   w_n;
  logic [IW-1:0]   w_end;
  logic            w_misaligned;
  logic            w_illegal;
  logic            w_beat;
  logic [NB-1:0]   w_lane_en;
  logic [LB-1:0]   w_lane_idx [NB];
  logic [DW-1:0]   w_lane_wd;
  logic [DW-1:0]   w_acc_next;
  logic [DW-1:0]   w_rext;
  logic            w_msb;

  // Lane steering is computed from the live request while idle (beat 1 is set up on the
  // accepting edge) and from the latched request afterwards.
  assign w_idle       = (r_state == S_IDLE);
  assign w_src_we     = w_idle ? we    : r_we;
  assign w_src_size   = w_idle ? size  : r_size;
  assign w_src_off    = w_idle ? addr[LB-1:0] : r_off;
  assign w_src_wdata  = w_idle ? wdata : r_wdata;
  assign w_n          = IW'(1) << w_src_size;
  assign w_end        = IW'(w_src_off) + w_n;
  assign w_misaligned = (w_end > IW'(NB));
  assign w_illegal    = (DW == 32) && (size == 2'd3);
  assign w_beat       = (r_state == S_BEAT2);

  // Byte at window position pos = beat*NB + offset maps to lane NB-1-offset and holds
  // value byte (pos - o), counted from the MSB.
  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    localparam logic [LB-1:0] Q = LB'(NB - 1 - gi);
    logic [IW-1:0] w_pos;
    logic [IW-1:0] w_rel;
    assign w_pos          = IW'({w_beat, Q});
    assign w_rel          = w_pos - IW'(w_src_off);
    assign w_lane_en[gi]  = (w_pos >= IW'(w_src_off)) && (w_rel < w_n);
    assign w_lane_idx[gi] = LB'(w_n - IW'(1) - w_rel);
    assign w_lane_wd[8*gi +: 8] = (w_lane_en[gi] && w_src_we) ?
                                  w_src_wdata[8*w_lane_idx[gi] +: 8] : 8'h00;
  end

  always_comb begin
    w_acc_next = r_acc;
    for (int k = 0; k < NB; k++) begin
      if (w_lane_en[k]) w_acc_next[8*w_lane_idx[k] +: 8] = readdata[8*k +: 8];
    end
  end

  always_comb begin
    w_msb = 1'b0;
    for (int m = 0; m < NB; m++) begin
      if (IW'(m) == w_n - IW'(1)) w_msb = w_acc_next[8*m+7];
    end
    w_rext = '0;
    for (int m = 0; m < NB; m++) begin
      w_rext[8*m +: 8] = (IW'(m) < w_n) ? w_acc_next[8*m +: 8] : {8{r_sign & w_msb}};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_we        <= 1'b0;
      r_sign      <= 1'b0;
      r_split     <= 1'b0;
      r_size      <= 2'd0;
      r_off       <= '0;
      r_base      <= '0;
      r_wdata     <= '0;
      r_acc       <= '0;
      r_rdata     <= '0;
      r_ack       <= 1'b0;
      r_fault     <= 1'b0;
      r_cause     <= 2'b00;
      r_busy      <= 1'b0;
      r_address   <= '0;
      r_read      <= 1'b0;
      r_write     <= 1'b0;
      r_writedata <= '0;
      r_be        <= '0;
    end else begin
      r_ack   <= 1'b0;
      r_fault <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_we    <= we;
            r_size  <= size;
            r_sign  <= sign;
            r_off   <= addr[LB-1:0];
            r_base  <= {addr[AW-1:LB], {LB{1'b0}}};
            r_wdata <= wdata;
            r_split <= w_misaligned;
            r_cause <= 2'b00;
            r_busy  <= 1'b1;
            if (w_illegal) begin
              r_state <= S_ERR;
              r_fault <= 1'b1;
              r_cause <= 2'b11;
            end else if (w_misaligned && !SPLIT_EN) begin
              r_state <= S_ERR;
              r_fault <= 1'b1;
              r_cause <= 2'b01;
            end else begin
              r_state     <= S_BEAT1;
              r_read      <= !we;
              r_write     <= we;
              r_address   <= {addr[AW-1:LB], {LB{1'b0}}};
              r_be        <= w_lane_en;
              r_writedata <= w_lane_wd;
            end
          end
        end
        S_BEAT1, S_BEAT2: begin
          // BEAT2 is entered with strobes low; the first cycle there is the inter-beat gap.
          if (r_state == S_BEAT2 && !r_read && !r_write) begin
            r_read      <= !r_we;
            r_write     <= r_we;
            r_address   <= r_base + AW'(NB);
            r_be        <= w_lane_en;
            r_writedata <= w_lane_wd;
          end else if (!waitrequest) begin
            r_read      <= 1'b0;
            r_write     <= 1'b0;
            r_be        <= '0;
            r_writedata <= '0;
            r_acc       <= w_acc_next;
            if (busfault) begin
              r_state <= S_ERR;
              r_fault <= 1'b1;
              r_cause <= 2'b10;
            end else if (r_state == S_BEAT1 && r_split) begin
              r_state <= S_BEAT2;
            end else begin
              r_state <= S_DONE;
              r_ack   <= 1'b1;
              if (!r_we) r_rdata <= w_rext;
            end
          end
        end
        S_DONE, S_ERR: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rdata       = r_rdata;
  assign ack         = r_ack;
  assign fault       = r_fault;
  assign fault_cause = r_cause;
  assign busy        = r_busy;
  assign address     = r_address;
  assign read        = r_read;
  assign write       = r_write;
  assign writedata   = r_writedata;
  assign byteenable  = r_be;

endmodule
